gups_mem: RTL and testbench

GUPS_MEM -- requirements
Module: gups_mem

---
 rtl/gups_pkg.sv | 14 +
 rtl/gups_ram.sv | 21 ++
 rtl/gups_mem.sv | 111 +++++++++++
 tb/tb_gups_mem.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gups_pkg.sv
// Shared constants and FSM state type for the GUPS memory model.
package gups_pkg;
   localparam int DATA_W     = 64;
   localparam int AW_DEF     = 13;
   localparam int RD_LAT_DEF = 2;
   localparam int WR_LAT_DEF = 5;

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;
endpackage

// File: rtl/gups_ram.sv
// Single-port synchronous RAM: one read or one write per clock, registered read data.
module gups_ram
   import gups_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     a,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[a] <= wd;
      else    q      <= mem[a];
   end

endmodule

// File: rtl/gups_mem.sv
// Latency-modelled memory for a GUPS update engine: self-initialising array,
// fixed read/write latency, one-cycle rdy pulse and completion statistics.
module gups_mem
   import gups_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int RD_LAT = RD_LAT_DEF,
   parameter int WR_LAT = WR_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       addr,
   input  logic [63:0]       dout,
   input  logic              req,
   input  logic              wr,
   output logic [63:0]       din,
   output logic              rdy,
   output logic              init_done,
   output logic [31:0]       rd_cnt,
   output logic [31:0]       wr_cnt,
   output logic [31:0]       err_cnt
);

   state_t            state;
   logic [AW-1:0]     idx;
   logic [3:0]        cnt;
   logic [AW-1:0]     a_lat;
   logic [DATA_W-1:0] d_lat;
   logic              wr_lat;
   logic              oor_lat;
   logic              commit;
   logic              accept;
   logic              ram_we;
   logic [AW-1:0]     ram_a;
   logic [DATA_W-1:0] ram_wd;
   logic [DATA_W-1:0] ram_q;

   assign accept = (state == S_IDLE) && req;
   assign commit = (state == S_WAIT) && (cnt == 4'd1);

   // The RAM keeps reading the latched address while waiting, so its
   // registered output already holds the word when the response edge arrives.
   assign ram_we = (state == S_INIT) || (commit && wr_lat && !oor_lat);
   assign ram_a  = (state == S_INIT) ? idx : a_lat;
   assign ram_wd = (state == S_INIT) ? DATA_W'(idx) : d_lat;

   gups_ram #(.AW(AW)) u_ram (
      .clk (clk),
      .we  (ram_we),
      .a   (ram_a),
      .wd  (ram_wd),
      .q   (ram_q)
   );

   always_ff @(posedge clk) begin
      if (accept) begin
         a_lat   <= addr[AW-1:0];
         d_lat   <= dout;
         wr_lat  <= wr;
         oor_lat <= |addr[63:AW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_INIT;
         idx       <= '0;
         cnt       <= '0;
         rdy       <= 1'b0;
         init_done <= 1'b0;
         din       <= '0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         err_cnt   <= '0;
      end else begin
         rdy <= 1'b0;
         case (state)
            S_INIT: begin
               idx <= idx + 1'b1;
               if (&idx) begin
                  state     <= S_IDLE;
                  init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (req) begin
                  cnt   <= wr ? 4'(WR_LAT) : 4'(RD_LAT);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= S_RESP;
                  rdy   <= 1'b1;
                  if (oor_lat) err_cnt <= err_cnt + 32'd1;
                  if (wr_lat) begin
                     wr_cnt <= wr_cnt + 32'd1;
                  end else begin
                     rd_cnt <= rd_cnt + 32'd1;
                     din    <= oor_lat ? '0 : ram_q;
                  end
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_gups_mem.sv
// Directed bench for gups_mem with AW=13, RD_LAT=2, WR_LAT=5.
module tb_gups_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] addr = '0;
   logic [63:0] dout = '0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [63:0] din;
   logic        rdy;
   logic        init_done;
   logic [31:0] rd_cnt, wr_cnt, err_cnt;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   gups_mem #(.AW(13), .RD_LAT(2), .WR_LAT(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .dout      (dout),
      .req       (req),
      .wr        (wr),
      .din       (din),
      .rdy       (rdy),
      .init_done (init_done),
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt),
      .err_cnt   (err_cnt)
   );

   // Issue one request; lat counts edges after the acceptance edge until rdy is seen.
   task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                         output int lat, output logic [63:0] rd, output logic pulse_ok);
      @(negedge clk);
      req = 1'b1; wr = w; addr = a; dout = d;
      @(posedge clk);
      lat = 99; rd = '0; pulse_ok = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rdy) begin
            lat = i; rd = din;
            break;
         end
      end
      @(posedge clk); #1;
      pulse_ok = !rdy;
      req = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy got %0b want 0", rdy); end
      vecs++; if (init_done !== 1'b0) begin errs++; $display("FAIL reset_init_done got %0b want 0", init_done); end
      vecs++; if (din !== 64'h0) begin errs++; $display("FAIL reset_din got %h want 0", din); end
      vecs++; if ({rd_cnt, wr_cnt, err_cnt} !== 96'h0) begin
         errs++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", rd_cnt, wr_cnt, err_cnt);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_init_pending();
      int n;
      int m;
      req = 1'b1; wr = 1'b0; addr = 64'd5;
      @(negedge clk); rst = 1'b1;
      n = 0;
      for (int i = 1; i <= 9000; i++) begin
         @(posedge clk); #1;
         if (init_done) begin n = i; break; end
      end
      vecs++; if (n != 8192) begin errs++; $display("FAIL init_time got %0d want 8192", n); end
      m = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rdy) begin m = n + i; break; end
      end
      vecs++; if (m != 8195) begin errs++; $display("FAIL pending_rdy_edge got %0d want 8195", m); end
      vecs++; if (din !== 64'd5) begin errs++; $display("FAIL pending_din got %h want 5", din); end
      @(posedge clk); #1;
      req = 1'b0;
      vecs++; if (rd_cnt !== 32'd1) begin errs++; $display("FAIL pending_rd_cnt got %0d want 1", rd_cnt); end
   endtask

   task automatic test_read();
      int lat; logic [63:0] rd; logic ok;
      do_req(1'b0, 64'd0, '0, lat, rd, ok);
      vecs++; if (rd !== 64'd0) begin errs++; $display("FAIL read0 got %h want 0", rd); end
      do_req(1'b0, 64'd8191, '0, lat, rd, ok);
      vecs++; if (rd !== 64'd8191) begin errs++; $display("FAIL read8191 got %h want 1fff", rd); end
      do_req(1'b0, 64'h10, '0, lat, rd, ok);
      vecs++; if (lat != 2) begin errs++; $display("FAIL read_lat got %0d want 2", lat); end
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL read_pulse got rdy held want single cycle"); end
      vecs++; if (rd !== 64'h10) begin errs++; $display("FAIL read10 got %h want 10", rd); end
      vecs++; if (rd_cnt !== 32'd4) begin errs++; $display("FAIL read_rd_cnt got %0d want 4", rd_cnt); end
   endtask

   task automatic test_write();
      int lat; logic [63:0] rd; logic ok;
      do_req(1'b1, 64'h10, 64'hDEAD_BEEF_0000_0011, lat, rd, ok);
      vecs++; if (lat != 5) begin errs++; $display("FAIL write_lat got %0d want 5", lat); end
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL write_pulse got rdy held want single cycle"); end
      vecs++; if (din !== 64'h10) begin errs++; $display("FAIL write_din_hold got %h want 10", din); end
      vecs++; if (wr_cnt !== 32'd1) begin errs++; $display("FAIL write_wr_cnt got %0d want 1", wr_cnt); end
      do_req(1'b0, 64'h10, '0, lat, rd, ok);
      vecs++; if (rd !== 64'hDEAD_BEEF_0000_0011) begin errs++; $display("FAIL write_readback got %h want deadbeef00000011", rd); end
      vecs++; if (rd_cnt !== 32'd5) begin errs++; $display("FAIL write_rd_cnt got %0d want 5", rd_cnt); end
   endtask

   task automatic test_oor();
      int lat; logic [63:0] rd; logic ok;
      do_req(1'b0, 64'h2000, '0, lat, rd, ok);
      vecs++; if (lat != 2) begin errs++; $display("FAIL oor_read_lat got %0d want 2", lat); end
      vecs++; if (rd !== 64'h0) begin errs++; $display("FAIL oor_read_din got %h want 0", rd); end
      vecs++; if (err_cnt !== 32'd1) begin errs++; $display("FAIL oor_err_cnt got %0d want 1", err_cnt); end
      vecs++; if (rd_cnt !== 32'd6) begin errs++; $display("FAIL oor_rd_cnt got %0d want 6", rd_cnt); end
      do_req(1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, ok);
      vecs++; if (lat != 5) begin errs++; $display("FAIL oor_write_lat got %0d want 5", lat); end
      vecs++; if (err_cnt !== 32'd2) begin errs++; $display("FAIL oor_err_cnt2 got %0d want 2", err_cnt); end
      vecs++; if (wr_cnt !== 32'd2) begin errs++; $display("FAIL oor_wr_cnt got %0d want 2", wr_cnt); end
      do_req(1'b0, 64'h0, '0, lat, rd, ok);
      vecs++; if (rd !== 64'h0) begin errs++; $display("FAIL oor_alias0 got %h want 0", rd); end
      do_req(1'b0, 64'h10, '0, lat, rd, ok);
      vecs++; if (rd !== 64'hDEAD_BEEF_0000_0011) begin errs++; $display("FAIL oor_word10 got %h want deadbeef00000011", rd); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [63:0] rd; logic ok;
      do_req(1'b1, 64'h20, 64'h0123_4567_89AB_CDEF, lat, rd, ok);
      vecs++; if (lat != 5) begin errs++; $display("FAIL b2b_write_lat got %0d want 5", lat); end
      do_req(1'b0, 64'h20, '0, lat, rd, ok);
      vecs++; if (lat != 2) begin errs++; $display("FAIL b2b_read_lat got %0d want 2", lat); end
      vecs++; if (rd !== 64'h0123_4567_89AB_CDEF) begin errs++; $display("FAIL b2b_read20 got %h want 0123456789abcdef", rd); end
      do_req(1'b0, 64'h21, '0, lat, rd, ok);
      vecs++; if (rd !== 64'h21) begin errs++; $display("FAIL b2b_read21 got %h want 21", rd); end
      vecs++; if ({rd_cnt, wr_cnt} !== {32'd10, 32'd3}) begin
         errs++; $display("FAIL b2b_counts got rd=%0d wr=%0d want rd=10 wr=3", rd_cnt, wr_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n; int seen; int lat; logic [63:0] rd; logic ok;
      seen = 0;
      @(negedge clk);
      req = 1'b1; wr = 1'b1; addr = 64'h30; dout = 64'hA5A5_A5A5_A5A5_A5A5;
      @(posedge clk);
      repeat (2) begin @(posedge clk); #1; if (rdy) seen++; end
      rst = 1'b0;
      #1;
      vecs++; if ({rd_cnt, wr_cnt, err_cnt} !== 96'h0) begin
         errs++; $display("FAIL mid_counters got %0d/%0d/%0d want 0/0/0", rd_cnt, wr_cnt, err_cnt);
      end
      vecs++; if (init_done !== 1'b0) begin errs++; $display("FAIL mid_init_done got %0b want 0", init_done); end
      req = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (rdy) seen++; end
      @(negedge clk); rst = 1'b1;
      n = 0;
      for (int i = 1; i <= 9000; i++) begin
         @(posedge clk); #1;
         if (rdy) seen++;
         if (init_done) begin n = i; break; end
      end
      vecs++; if (seen != 0) begin errs++; $display("FAIL mid_no_rdy got %0d pulses want 0", seen); end
      vecs++; if (n != 8192) begin errs++; $display("FAIL mid_reinit_time got %0d want 8192", n); end
      do_req(1'b0, 64'h30, '0, lat, rd, ok);
      vecs++; if (rd !== 64'h30) begin errs++; $display("FAIL mid_word30 got %h want 30", rd); end
      vecs++; if ({rd_cnt, wr_cnt, err_cnt} !== {32'd1, 32'd0, 32'd0}) begin
         errs++; $display("FAIL mid_counts got %0d/%0d/%0d want 1/0/0", rd_cnt, wr_cnt, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_init_pending();
      test_read();
      test_write();
      test_oor();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
